// File: rtl/risc_exec_core.sv
// Multicycle execute core for the ADD/NAND ALU instruction class.
// Owns an 8-entry register file, carry/zero flags and an IDLE/DECODE/EXEC/WB sequencer.
module risc_exec_core #(
    parameter int DATA_W       = 16,
    parameter int LOAD_IN_BUSY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              illegal,
    output logic              carry,
    output logic              zero,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              cond_q, cond_d;
    logic [DATA_W:0]   res_q, res_d;    // bit DATA_W holds the ADD carry-out
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic [3:0] opcode;
    logic [2:0] ra, rb, rc;
    logic       comp;
    logic [1:0] cz;
    logic       legal;
    logic       cin;
    logic       ld_ok;

    assign opcode = ir_q[15:12];
    assign ra     = ir_q[11:9];
    assign rb     = ir_q[8:6];
    assign rc     = ir_q[5:3];
    assign comp   = ir_q[2];
    assign cz     = ir_q[1:0];

    assign legal = (opcode == OP_ADD) || ((opcode == OP_NAND) && (cz != 2'b11));
    assign cin   = (cz == 2'b11) ? carry_q : 1'b0;
    assign ld_ok = ld_en && ((LOAD_IN_BUSY != 0) || (state_q == S_IDLE));

    assign instr_ready = (state_q == S_IDLE);
    assign dbg_data    = regs_q[dbg_addr];
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        cond_d  = cond_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        regs_d  = regs_q;
        wb_en   = 1'b0;
        wb_addr = 3'd0;
        wb_data = '0;
        done    = 1'b0;
        illegal = 1'b0;

        // Preload goes first so a WB write to the same index overrides it.
        if (ld_ok) begin
            regs_d[ld_addr] = ld_data;
        end

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = regs_q[ra];
                b_d = comp ? ~regs_q[rb] : regs_q[rb];
                case (cz)
                    2'b10:   cond_d = carry_q;
                    2'b01:   cond_d = zero_q;
                    default: cond_d = 1'b1;
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_NAND) begin
                    res_d = {1'b0, ~(a_q & b_q)};
                end else begin
                    res_d = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, cin};
                end
                state_d = S_WB;
            end
            S_WB: begin
                done    = 1'b1;
                illegal = !legal;
                if (legal && cond_q) begin
                    wb_en      = 1'b1;
                    wb_addr    = rc;
                    wb_data    = res_q[DATA_W-1:0];
                    regs_d[rc] = res_q[DATA_W-1:0];
                    zero_d     = (res_q[DATA_W-1:0] == '0);
                    if (opcode == OP_ADD) begin
                        carry_d = res_q[DATA_W];
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cond_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cond_q  <= cond_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_risc_exec_core.sv
// Directed bench for risc_exec_core: a 16-bit instance for the instruction set
// and an 8-bit instance (preload allowed while busy) for width and back-to-back handshake.
module tb_risc_exec_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        instr_valid, instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr, dbg_addr, wb_addr;
    logic [15:0] ld_data, dbg_data, wb_data;
    logic        wb_en, done, illegal, carry, zero;
    logic [1:0]  state;

    logic        instr_valid8, instr_ready8;
    logic [15:0] instr8;
    logic        ld_en8;
    logic [2:0]  ld_addr8, dbg_addr8, wb_addr8;
    logic [7:0]  ld_data8, dbg_data8, wb_data8;
    logic        wb_en8, done8, illegal8, carry8, zero8;
    logic [1:0]  state8;

    risc_exec_core #(.DATA_W(16), .LOAD_IN_BUSY(0)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .done(done), .illegal(illegal), .carry(carry), .zero(zero),
        .state(state)
    );

    risc_exec_core #(.DATA_W(8), .LOAD_IN_BUSY(1)) dut8 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid8), .instr_ready(instr_ready8),
        .instr(instr8), .ld_en(ld_en8), .ld_addr(ld_addr8), .ld_data(ld_data8),
        .dbg_addr(dbg_addr8), .dbg_data(dbg_data8), .wb_en(wb_en8), .wb_addr(wb_addr8),
        .wb_data(wb_data8), .done(done8), .illegal(illegal8), .carry(carry8), .zero(zero8),
        .state(state8)
    );

    int checks = 0;
    int errors = 0;

    logic        s_done, s_wb_en, s_ill;
    logic [2:0]  s_wa;
    logic [15:0] s_wd;
    logic [15:0] rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Issues one instruction and follows it through all four states, capturing WB outputs.
    task automatic run(input logic [15:0] ins);
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("state DECODE", state, 1);
        chk("ready low DECODE", instr_ready, 0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("state EXEC", state, 2);
        chk("done low EXEC", done, 0);
        @(posedge clk); #1;
        chk("state WB", state, 3);
        s_done = done; s_wb_en = wb_en; s_ill = illegal; s_wa = wb_addr; s_wd = wb_data;
        @(posedge clk); #1;
        chk("state IDLE", state, 0);
        chk("done one cycle", done, 0);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        instr_valid8 = 1'b0; instr8 = '0; ld_en8 = 1'b0; ld_addr8 = '0; ld_data8 = '0; dbg_addr8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset state", state, 0);
        chk("reset ready", instr_ready, 1);
        chk("reset carry", carry, 0);
        chk("reset zero", zero, 0);
        chk("reset wb_en", wb_en, 0);
        chk("reset wb_addr", wb_addr, 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset done", done, 0);
        chk("reset illegal", illegal, 0);
        rd(3'd5, rv); chk("reset R5", rv, 0);

        // Basic ADD R4 = R1 + R2
        preload(3'd1, 16'h000F);
        preload(3'd2, 16'h0012);
        run(16'h02A0);
        chk("add done", s_done, 1);
        chk("add wb_en", s_wb_en, 1);
        chk("add wb_addr", s_wa, 4);
        chk("add wb_data", s_wd, 16'h0021);
        chk("add illegal", s_ill, 0);
        rd(3'd4, rv); chk("add R4", rv, 16'h0021);
        chk("add carry", carry, 0);
        chk("add zero", zero, 0);

        // Carry and zero set together
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        run(16'h02A0);
        rd(3'd4, rv); chk("wrap R4", rv, 16'h0000);
        chk("wrap carry", carry, 1);
        chk("wrap zero", zero, 1);

        // AWC consumes carry-in
        preload(3'd1, 16'h0001);
        preload(3'd2, 16'h0001);
        run(16'h02A3);
        rd(3'd4, rv); chk("awc R4", rv, 16'h0003);
        chk("awc carry", carry, 0);
        chk("awc zero", zero, 0);

        // Conditional skips with both flags clear
        run(16'h02A0);
        rd(3'd4, rv); chk("clear R4", rv, 16'h0002);
        run(16'h02A1);
        chk("adz done", s_done, 1);
        chk("adz wb_en", s_wb_en, 0);
        rd(3'd4, rv); chk("adz R4 kept", rv, 16'h0002);
        chk("adz carry kept", carry, 0);
        chk("adz zero kept", zero, 0);
        run(16'h02A2);
        chk("adc skip wb_en", s_wb_en, 0);
        rd(3'd4, rv); chk("adc skip R4", rv, 16'h0002);

        // Complemented ADD, NAND, ADC taken
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        run(16'h02A4);
        rd(3'd4, rv); chk("acomp R4", rv, 16'h0001);
        chk("acomp carry", carry, 1);
        run(16'h22A0);
        chk("nand wb_data", s_wd, 16'hFFFE);
        rd(3'd4, rv); chk("nand R4", rv, 16'hFFFE);
        chk("nand carry kept", carry, 1);
        chk("nand zero", zero, 0);
        run(16'h02A2);
        chk("adc take wb_en", s_wb_en, 1);
        rd(3'd4, rv); chk("adc take R4", rv, 16'h0008);
        chk("adc take carry", carry, 0);

        // Illegal opcodes with carry set
        run(16'h02A4);
        chk("acomp2 carry", carry, 1);
        run(16'hF000);
        chk("illegal flag", s_ill, 1);
        chk("illegal done", s_done, 1);
        chk("illegal wb_en", s_wb_en, 0);
        rd(3'd4, rv); chk("illegal R4 kept", rv, 16'h0001);
        chk("illegal carry kept", carry, 1);
        run(16'h22A3);
        chk("nand cz11 illegal", s_ill, 1);
        chk("nand cz11 wb_en", s_wb_en, 0);

        // Reset while in EXEC
        @(negedge clk);
        instr = 16'h02A0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset EXEC", state, 2);
        reset = 1'b1;
        #1;
        chk("midop reset state", state, 0);
        chk("midop reset carry", carry, 0);
        for (int a = 0; a < 8; a++) begin
            rd(a[2:0], rv); chk("midop reset reg", rv, 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("no done after reset", done, 0);
            chk("idle after reset", state, 0);
        end
        preload(3'd1, 16'h0007);
        preload(3'd2, 16'h0009);
        run(16'h02A0);
        rd(3'd4, rv); chk("post-reset R4", rv, 16'h0010);

        // Preload on the accept edge is visible to DECODE; preload while busy is dropped
        @(negedge clk);
        instr = 16'h02A0; instr_valid = 1'b1;
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0100;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ld_addr = 3'd7; ld_data = 16'hAAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("coinc idle", state, 0);
        rd(3'd4, rv); chk("coinc preload R4", rv, 16'h0109);
        rd(3'd7, rv); chk("busy preload dropped", rv, 0);

        // 8-bit instance: back-to-back issue, busy preload, WB wins a collision
        @(negedge clk);
        ld_en8 = 1'b1; ld_addr8 = 3'd1; ld_data8 = 8'hF0;
        @(negedge clk);
        ld_addr8 = 3'd2; ld_data8 = 8'h20;
        @(negedge clk);
        ld_en8 = 1'b0; instr8 = 16'h02A0; instr_valid8 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("b2b state", state8, (k + 1) % 4);
            chk("b2b ready", instr_ready8, ((k + 1) % 4) == 0);
            chk("b2b done", done8, ((k + 1) % 4) == 3);
            if (((k + 1) % 4) == 3) begin
                chk("b2b wb_data", wb_data8, 8'h10);
            end
            ld_en8   = (k == 1) || (k == 2);
            ld_addr8 = (k == 1) ? 3'd3 : 3'd4;
            ld_data8 = (k == 1) ? 8'h5A : 8'hEE;
        end
        instr_valid8 = 1'b0;
        ld_en8 = 1'b0;
        @(posedge clk); #1;
        chk("b2b stays idle", state8, 0);
        dbg_addr8 = 3'd4; #1;
        chk("w8 R4", dbg_data8, 8'h10);
        dbg_addr8 = 3'd3; #1;
        chk("w8 busy preload R3", dbg_data8, 8'h5A);
        chk("w8 carry", carry8, 1);
        chk("w8 zero", zero8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
